// File: rtl/fwd_hazard_if.sv
// fwd_hazard_if -- ID-stage request / EX-stage control bundle for fwd_hazard_unit.
//   master : decode side, drives the ID instruction fields and flush, and
//            receives stall, forward selects, ex_valid and stall_count.
//   slave  : the hazard unit.
// SELW is the forward-select width, ceil(log2(FWD_STAGES+1)).
interface fwd_hazard_if #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  logic              id_valid;
  logic [REG_AW-1:0] id_rs1;
  logic [REG_AW-1:0] id_rs2;
  logic              id_use_rs1;
  logic              id_use_rs2;
  logic [REG_AW-1:0] id_rd;
  logic              id_regw;
  logic              id_load;
  logic              flush;
  logic              stall;
  logic [SELW-1:0]   fwd_a;
  logic [SELW-1:0]   fwd_b;
  logic              ex_valid;
  logic [15:0]       stall_count;

  modport master (
    output id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regw, id_load, flush,
    input  stall, fwd_a, fwd_b, ex_valid, stall_count
  );

  modport slave (
    input  id_valid, id_rs1, id_rs2, id_use_rs1, id_use_rs2,
           id_rd, id_regw, id_load, flush,
    output stall, fwd_a, fwd_b, ex_valid, stall_count
  );
endinterface

// File: rtl/fwd_hazard_unit.sv
// fwd_hazard_unit -- operand forwarding select and load-use stall generation.
// Tracks the FWD_STAGES instructions past ID (entry 0 = EX) and, for each ID
// source, picks the youngest in-flight producer of that register.
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : fwd_hazard_if.slave
//     in  id_valid/id_rs1/id_rs2/id_use_rs1/id_use_rs2/id_rd/id_regw/id_load, flush
//     out stall (comb), fwd_a/fwd_b (registered, 0 = regfile, s = stage s),
//         ex_valid, stall_count (saturating)
module fwd_hazard_unit #(
  parameter int REG_AW     = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_STAGE = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  fwd_hazard_if.slave  bus
);
  localparam int SELW = $clog2(FWD_STAGES + 1);

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              regw;
    logic              load;
  } ent_t;

  ent_t [FWD_STAGES-1:0] pipe_q, pipe_d;
  logic [SELW-1:0]       fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
  logic [15:0]           cnt_q, cnt_d;

  logic [1:0][REG_AW-1:0] src;
  logic [1:0]             use_src;
  logic [1:0][SELW-1:0]   sel;
  logic [1:0]             haz;
  logic                   bubble;

  assign src     = {bus.id_rs2, bus.id_rs1};
  assign use_src = {bus.id_use_rs2, bus.id_use_rs1};

  // Scan oldest to youngest so the youngest match overwrites older ones.
  // A load match is a hazard only while its data is not yet forwardable.
  always_comb begin
    sel = '0;
    haz = '0;
    for (int s = 0; s < 2; s++) begin
      for (int i = FWD_STAGES - 1; i >= 0; i--) begin
        if (pipe_q[i].valid && pipe_q[i].regw && use_src[s] &&
            (src[s] != '0) && (pipe_q[i].rd == src[s])) begin
          sel[s] = SELW'(i + 1);
          haz[s] = pipe_q[i].load && ((i + 1) < LOAD_STAGE);
        end
      end
    end
  end

  // Flush dominates: a killed instruction can never request a stall.
  assign bus.stall = bus.id_valid & ~bus.flush & (|haz);
  assign bubble    = ~bus.id_valid | bus.flush | bus.stall;

  always_comb begin
    pipe_d          = '0;
    pipe_d[0].valid = ~bubble;
    pipe_d[0].rd    = bus.id_rd;
    pipe_d[0].regw  = bus.id_regw;
    pipe_d[0].load  = bus.id_load;
    for (int i = 1; i < FWD_STAGES; i++) pipe_d[i] = pipe_q[i-1];
    fwd_a_d = bubble ? '0 : sel[0];
    fwd_b_d = bubble ? '0 : sel[1];
    cnt_d   = (bus.stall && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pipe_q  <= '0;
      fwd_a_q <= '0;
      fwd_b_q <= '0;
      cnt_q   <= '0;
    end else begin
      pipe_q  <= pipe_d;
      fwd_a_q <= fwd_a_d;
      fwd_b_q <= fwd_b_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.fwd_a       = fwd_a_q;
  assign bus.fwd_b       = fwd_b_q;
  assign bus.ex_valid    = pipe_q[0].valid;
  assign bus.stall_count = cnt_q;
endmodule

// File: tb/tb_fwd_hazard_unit.sv
module tb_fwd_hazard_unit;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_pass = 0;
  int   n_tot  = 0;

  always #5 clk = ~clk;

  fwd_hazard_if #(.REG_AW(5), .FWD_STAGES(2)) ifa ();
  fwd_hazard_if #(.REG_AW(5), .FWD_STAGES(4)) ifb ();
  fwd_hazard_if #(.REG_AW(5), .FWD_STAGES(6)) ifc ();

  fwd_hazard_unit #(.REG_AW(5), .FWD_STAGES(2), .LOAD_STAGE(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(ifa));
  fwd_hazard_unit #(.REG_AW(5), .FWD_STAGES(4), .LOAD_STAGE(3)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(ifb));
  fwd_hazard_unit #(.REG_AW(5), .FWD_STAGES(6), .LOAD_STAGE(6)) dut_c (
    .clk(clk), .rst_n(rst_n), .bus(ifc));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tot++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic id_a(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rs2, input logic u2,
                      input logic [4:0] rd, input logic rw, input logic ld,
                      input logic fl);
    ifa.id_valid = v;  ifa.id_rs1 = rs1; ifa.id_use_rs1 = u1;
    ifa.id_rs2 = rs2;  ifa.id_use_rs2 = u2;
    ifa.id_rd = rd;    ifa.id_regw = rw; ifa.id_load = ld; ifa.flush = fl;
    #1;
  endtask

  task automatic id_b(input logic v, input logic [4:0] rs1, input logic u1,
                      input logic [4:0] rd, input logic rw, input logic ld);
    ifb.id_valid = v;  ifb.id_rs1 = rs1; ifb.id_use_rs1 = u1;
    ifb.id_rs2 = 5'd0; ifb.id_use_rs2 = 1'b0;
    ifb.id_rd = rd;    ifb.id_regw = rw; ifb.id_load = ld; ifb.flush = 1'b0;
    #1;
  endtask

  initial begin
    id_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    id_b(0, 0, 0, 0, 0, 0);
    ifc.id_valid = 0; ifc.id_rs1 = 0; ifc.id_use_rs1 = 0; ifc.id_rs2 = 0;
    ifc.id_use_rs2 = 0; ifc.id_rd = 0; ifc.id_regw = 0; ifc.id_load = 0;
    ifc.flush = 0;

    // reset state
    #12;
    chk("rst_stall", ifa.stall, 0);
    chk("rst_fwd_a", ifa.fwd_a, 0);
    chk("rst_fwd_b", ifa.fwd_b, 0);
    chk("rst_ex_valid", ifa.ex_valid, 0);
    chk("rst_cnt", ifa.stall_count, 0);
    rst_n = 1'b1;
    tick();
    chk("post_rst_stall", ifa.stall, 0);

    // ALU -> ALU forwarding at distance 1, 2, then out of range
    id_a(1, 1, 1, 2, 1, 5, 1, 0, 0);           // ADD x5
    tick();
    chk("alu_ex_valid", ifa.ex_valid, 1);
    id_a(1, 5, 1, 0, 0, 6, 1, 0, 0);           // ADD x6, rs1=x5
    chk("alu_nostall", ifa.stall, 0);
    tick();
    chk("alu_fwd_a1", ifa.fwd_a, 1);
    chk("alu_fwd_b1", ifa.fwd_b, 0);
    id_a(1, 5, 1, 0, 0, 8, 1, 0, 0);           // ADD x8, rs1=x5 (one between)
    tick();
    chk("alu_fwd_a2", ifa.fwd_a, 2);
    id_a(1, 5, 1, 0, 0, 10, 1, 0, 0);          // x5 producer has left
    tick();
    chk("alu_fwd_gone", ifa.fwd_a, 0);

    // load-use: one stall, EX bubble, then forward from stage 2
    id_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    id_a(1, 1, 1, 0, 0, 7, 1, 1, 0);           // LW x7
    tick();
    id_a(1, 4, 1, 7, 1, 11, 1, 0, 0);          // ADD rs2=x7
    chk("lu_stall", ifa.stall, 1);
    tick();
    chk("lu_bubble", ifa.ex_valid, 0);
    chk("lu_bubble_fwd_b", ifa.fwd_b, 0);
    chk("lu_cnt1", ifa.stall_count, 1);
    chk("lu_stall_clear", ifa.stall, 0);
    tick();
    chk("lu_fwd_b", ifa.fwd_b, 2);
    chk("lu_ex_valid", ifa.ex_valid, 1);
    chk("lu_cnt_hold", ifa.stall_count, 1);

    // youngest of two producers wins; x0 never forwards or stalls
    id_a(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    id_a(1, 0, 0, 0, 0, 3, 1, 0, 0);
    tick();
    id_a(1, 3, 1, 3, 1, 12, 1, 0, 0);
    tick();
    chk("young_fwd_a", ifa.fwd_a, 1);
    chk("young_fwd_b", ifa.fwd_b, 1);
    id_a(1, 0, 0, 0, 0, 0, 1, 1, 0);           // LW x0
    tick();
    id_a(1, 0, 1, 0, 1, 13, 1, 0, 0);
    chk("x0_nostall", ifa.stall, 0);
    tick();
    chk("x0_fwd_a", ifa.fwd_a, 0);
    chk("x0_fwd_b", ifa.fwd_b, 0);
    id_a(1, 13, 0, 0, 0, 14, 1, 0, 0);         // rs1 match but not read
    tick();
    chk("nouse_fwd_a", ifa.fwd_a, 0);

    // flush beats load-use stall
    id_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    id_a(1, 1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    id_a(1, 0, 0, 7, 1, 11, 1, 0, 1);
    chk("flush_nostall", ifa.stall, 0);
    tick();
    chk("flush_bubble", ifa.ex_valid, 0);
    chk("flush_cnt", ifa.stall_count, 1);

    // reset in the middle of a stall
    id_a(0, 0, 0, 0, 0, 0, 0, 0, 0);
    tick(); tick();
    id_a(1, 1, 1, 0, 0, 7, 1, 1, 0);
    tick();
    id_a(1, 0, 0, 7, 1, 11, 1, 0, 0);
    chk("mid_stall", ifa.stall, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_stall", ifa.stall, 0);
    chk("mid_rst_ex_valid", ifa.ex_valid, 0);
    chk("mid_rst_fwd_a", ifa.fwd_a, 0);
    chk("mid_rst_fwd_b", ifa.fwd_b, 0);
    chk("mid_rst_cnt", ifa.stall_count, 0);
    #1;
    rst_n = 1'b1;
    tick();
    chk("after_rst_ex_valid", ifa.ex_valid, 1);
    chk("after_rst_fwd_b", ifa.fwd_b, 0);
    chk("after_rst_cnt", ifa.stall_count, 0);
    id_a(0, 0, 0, 0, 0, 0, 0, 0, 0);

    // deeper pipe, load forwardable from stage 3
    id_b(1, 1, 1, 9, 1, 1);                    // LW x9
    tick();
    id_b(1, 9, 1, 15, 1, 0);
    chk("d4_stall1", ifb.stall, 1);
    tick();
    chk("d4_stall2", ifb.stall, 1);
    chk("d4_bubble", ifb.ex_valid, 0);
    tick();
    chk("d4_stall_end", ifb.stall, 0);
    chk("d4_cnt2", ifb.stall_count, 2);
    tick();
    chk("d4_fwd_a", ifb.fwd_a, 3);
    id_b(0, 0, 0, 0, 0, 0);
    tick(); tick(); tick(); tick();
    id_b(1, 1, 1, 9, 1, 1);                    // LW x9
    tick();
    id_b(1, 2, 1, 10, 1, 0);                   // independent
    tick();
    id_b(1, 9, 1, 15, 1, 0);
    chk("d4_gap_stall", ifb.stall, 1);
    tick();
    chk("d4_gap_stall_end", ifb.stall, 0);
    chk("d4_gap_cnt", ifb.stall_count, 3);
    tick();
    chk("d4_gap_fwd_a", ifb.fwd_a, 3);
    id_b(0, 0, 0, 0, 0, 0);

    // counter saturation: self-dependent LW x9 stalls 5 of every 6 cycles
    ifc.id_valid = 1; ifc.id_rs1 = 5'd9; ifc.id_use_rs1 = 1;
    ifc.id_rd = 5'd9; ifc.id_regw = 1;   ifc.id_load = 1;
    for (int k = 0; k < 12; k++) tick();
    chk("sat_cnt_early", ifc.stall_count, 10);
    for (int k = 0; k < 78700; k++) tick();
    chk("sat_cnt_max", ifc.stall_count, 16'hFFFF);
    for (int k = 0; k < 30; k++) tick();
    chk("sat_cnt_hold", ifc.stall_count, 16'hFFFF);
    ifc.id_valid = 0;

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
